// File: rtl/rolled_accumulator.sv
// rolled_accumulator: sums NUM signed elements arriving ROLL_NUM per beat into one result per vector.
module rolled_accumulator #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM        = 8,
    parameter int ROLL_NUM   = 2,
    parameter int OUT_WIDTH  = DATA_WIDTH + $clog2(NUM)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [DATA_WIDTH-1:0] data_in [ROLL_NUM],
    input  logic                         data_in_valid,
    output logic                         data_in_ready,
    output logic signed [OUT_WIDTH-1:0]  data_out,
    output logic                         data_out_valid,
    input  logic                         data_out_ready
);
    localparam int CYCLES = NUM / ROLL_NUM;
    localparam int CW     = CYCLES > 1 ? $clog2(CYCLES) : 1;

    if (NUM % ROLL_NUM != 0) begin : g_bad_roll
        $error("rolled_accumulator: NUM must be a multiple of ROLL_NUM");
    end

    logic [CW-1:0]               cnt_q, cnt_d;
    logic signed [OUT_WIDTH-1:0] acc_q, acc_d, out_q, out_d, chunk_sum;
    logic                        valid_q, valid_d, last, fire;

    always_comb begin
        chunk_sum = '0;
        for (int i = 0; i < ROLL_NUM; i++) chunk_sum = chunk_sum + OUT_WIDTH'(data_in[i]);
    end

    // Only the final beat can be blocked, and only by an unconsumed result.
    assign last          = cnt_q == CW'(CYCLES - 1);
    assign data_in_ready = !last || !valid_q || data_out_ready;
    assign fire          = data_in_valid && data_in_ready;

    always_comb begin
        cnt_d   = fire ? (last ? '0 : cnt_q + CW'(1)) : cnt_q;
        acc_d   = fire ? (last ? '0 : acc_q + chunk_sum) : acc_q;
        out_d   = fire && last ? acc_q + chunk_sum : out_q;
        valid_d = fire && last ? 1'b1 : (data_out_ready ? 1'b0 : valid_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            acc_q   <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign data_out       = out_q;
    assign data_out_valid = valid_q;
endmodule

// File: tb/tb_rolled_accumulator.sv
// tb_rolled_accumulator: random and directed stimulus checked against a queue-based vector-sum model.
module tb_rolled_accumulator;
    localparam int DW = 16, NUM = 8, RN = 2, OW = 19;

    logic                 clk = 0, rst = 1;
    logic signed [DW-1:0] data_in [RN];
    logic                 data_in_valid = 0, data_in_ready, data_out_valid, data_out_ready = 0;
    logic signed [OW-1:0] data_out;

    rolled_accumulator #(.DATA_WIDTH(DW), .NUM(NUM), .ROLL_NUM(RN), .OUT_WIDTH(OW)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .data_in_valid(data_in_valid),
        .data_in_ready(data_in_ready), .data_out(data_out), .data_out_valid(data_out_valid),
        .data_out_ready(data_out_ready)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    int part[$];
    bit m_valid;
    int m_out;

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        part.delete();
        m_valid = 0;
        m_out   = 0;
    endtask

    task automatic cycle();
        bit rdy, fire, fin;
        int s;
        @(negedge clk);
        rdy = (part.size() != NUM - RN) || !m_valid || data_out_ready;
        check("in_ready", {31'b0, data_in_ready}, {31'b0, rdy});
        fire = data_in_valid && rdy;
        fin  = 0;
        @(posedge clk);
        #1;
        if (fire) begin
            for (int i = 0; i < RN; i++) part.push_back(int'(data_in[i]));
            fin = part.size() == NUM;
        end
        if (fin) begin
            s = 0;
            foreach (part[i]) s += part[i];
            part.delete();
            m_out   = s;
            m_valid = 1;
        end else if (m_valid && data_out_ready) m_valid = 0;
        check("out_valid", {31'b0, data_out_valid}, {31'b0, m_valid});
        check("data_out", 32'(data_out), m_out);
    endtask

    task automatic beat(input bit v, input int a, input int b, input bit r);
        data_in_valid  = v;
        data_in[0]     = DW'(a);
        data_in[1]     = DW'(b);
        data_out_ready = r;
        cycle();
    endtask

    function automatic int rnd_elem();
        int k = int'($urandom_range(0, 7));
        return k == 0 ? -32768 : k == 1 ? 32767 : int'($urandom_range(0, 65535)) - 32768;
    endfunction

    initial begin
        data_in[0] = '0;
        data_in[1] = '0;
        model_reset();
        #1 rst = 0;
        #2;
        check("rst_valid", {31'b0, data_out_valid}, 0);
        check("rst_out", 32'(data_out), 0);
        check("rst_ready", {31'b0, data_in_ready}, 1);
        @(posedge clk);
        #2 rst = 1;

        for (int i = 0; i < 4; i++) beat(1, 2 * i + 1, 2 * i + 2, 1);
        check("single_sum", 32'(data_out), 36);
        beat(0, 0, 0, 1);
        check("single_one_cycle", {31'b0, data_out_valid}, 0);

        for (int i = 0; i < 4; i++) beat(1, -32768, -32768, 1);
        check("neg_extreme", 32'(data_out), -262144);
        for (int i = 0; i < 4; i++) beat(1, 32767, 32767, 1);
        check("pos_extreme", 32'(data_out), 262136);
        beat(0, 0, 0, 1);

        for (int i = 0; i < 4; i++) beat(1, 2 * i + 1, 2 * i + 2, 0);
        for (int i = 0; i < 3; i++) beat(1, 1, 1, 0);
        data_in_valid = 1;
        data_out_ready = 0;
        #3;
        check("bp_ready_low", {31'b0, data_in_ready}, 0);
        cycle();
        beat(1, 1, 1, 0);
        check("bp_hold", 32'(data_out), 36);
        beat(1, 1, 1, 1);
        check("bp_new_sum", 32'(data_out), 8);
        check("bp_no_bubble", {31'b0, data_out_valid}, 1);
        beat(0, 0, 0, 1);

        for (int v = 0; v < 3; v++)
            for (int i = 0; i < 4; i++) beat(1, v * 10 + i, -i, 1);
        beat(0, 0, 0, 1);

        for (int i = 0; i < 4; i++) begin
            beat(1, 2 * i + 1, 2 * i + 2, 1);
            if (i < 3) beat(0, 99, 99, 1);
        end
        check("gap_sum", 32'(data_out), 36);
        beat(0, 0, 0, 1);

        beat(1, 100, 100, 1);
        beat(1, 100, 100, 1);
        data_in_valid = 0;
        #3 rst = 0;
        #1;
        check("amid_valid", {31'b0, data_out_valid}, 0);
        check("amid_out", 32'(data_out), 0);
        check("amid_ready", {31'b0, data_in_ready}, 1);
        model_reset();
        #7 rst = 1;
        for (int i = 0; i < 4; i++) beat(1, 1, 1, 1);
        check("reset_discard", 32'(data_out), 8);

        for (int i = 0; i < 400; i++)
            beat($urandom_range(0, 3) != 0, rnd_elem(), rnd_elem(), $urandom_range(0, 2) != 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
